// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the PC/instruction-fetch stage
package fetch_pkg;

    localparam logic [63:0] RESET_PC_DEF  = 64'h0;
    localparam int          INSTR_W_DEF   = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'hD503201F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [63:0]            pc;
        logic [INSTR_W_DEF-1:0] instr;
        logic                   valid;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, bubble and flush controls
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               bubble_i,
    input  logic [63:0]        pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [63:0]        pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [63:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    // Flush beats load beats bubble; with none asserted the register holds.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end else if (bubble_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 64'h0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register, IMEM fetch FSM, skid buffer and redirect; perf counters under FETCH_PERF_CNT_EN
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0]        RESET_PC  = RESET_PC_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [63:0]        pc_o,
    input  logic [63:0]        pc_plus1_i,
    input  logic               br_taken_i,
    input  logic [63:0]        br_target_i,
    input  logic               stall_i,
    output logic               imem_req_o,
    output logic [63:0]        imem_addr_o,
    input  logic               imem_rdy_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [63:0]        ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        stall_cnt_o
`endif
);

    fetch_state_e       state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [63:0]        skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [63:0]        pend_tgt_q, pend_tgt_d;

    logic               done;
    logic               ld, flush, bubble;
    logic [63:0]        ld_pc;
    logic [INSTR_W-1:0] ld_instr;

    assign imem_req_o  = (state_q == ST_REQ) || (state_q == ST_KILL);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign done        = imem_req_o && imem_rdy_i;

    // The skid buffer is full exactly while in HOLD, so it needs no valid bit.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pend_tgt_d   = pend_tgt_q;
        ld           = 1'b0;
        flush        = 1'b0;
        bubble       = 1'b0;
        ld_pc        = pc_q;
        ld_instr     = imem_data_i;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (br_taken_i) begin
                    flush = 1'b1;
                    pc_d  = br_target_i;
                end
            end
            ST_REQ: begin
                if (br_taken_i) begin
                    flush = 1'b1;
                    if (done) begin
                        pc_d = br_target_i;
                    end else begin
                        pend_tgt_d = br_target_i;
                        state_d    = ST_KILL;
                    end
                end else if (done) begin
                    pc_d = pc_plus1_i;
                    if (stall_i) begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_data_i;
                        state_d      = ST_HOLD;
                    end else begin
                        ld = 1'b1;
                    end
                end else if (!stall_i) begin
                    bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (br_taken_i) begin
                    flush   = 1'b1;
                    pc_d    = br_target_i;
                    state_d = ST_REQ;
                end else if (!stall_i) begin
                    ld       = 1'b1;
                    ld_pc    = skid_pc_q;
                    ld_instr = skid_instr_q;
                    state_d  = ST_REQ;
                end
            end
            ST_KILL: begin
                // A redirect arriving on the completing cycle is the newest target.
                if (br_taken_i) begin
                    flush      = 1'b1;
                    pend_tgt_d = br_target_i;
                end
                if (done) begin
                    pc_d    = br_taken_i ? br_target_i : pend_tgt_q;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            skid_pc_q    <= 64'h0;
            skid_instr_q <= NOP_INSTR;
            pend_tgt_q   <= 64'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    ifid_reg #(
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ld),
        .flush_i  (flush),
        .bubble_i (bubble),
        .pc_i     (ld_pc),
        .instr_i  (ld_instr),
        .pc_o     (ifid_pc_o),
        .instr_o  (ifid_instr_o),
        .valid_o  (ifid_valid_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (ld && !flush && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
